// File: rtl/viterbi_ber_ctrl.sv
// viterbi_ber_ctrl: frame sequencer and BER controller for the Viterbi encoder/decoder chain.
// Optional macro VITERBI_ERR_BURST_EN: each error trigger flips both bits of two consecutive symbols.
module viterbi_ber_ctrl #(
    parameter int          FRAME_LEN = 256,
    parameter int          TAIL      = 2,
    parameter int          DEC_LAT   = 16,
    parameter int          ERR_SHIFT = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        dec_bit_i,
    output logic        enc_en_o,
    output logic        enc_bit_o,
    output logic [1:0]  err_mask_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [15:0] bit_err_ct_o,
    output logic [15:0] inj_ct_o
);
    localparam logic [2:0]  S_IDLE  = 3'd0;
    localparam logic [2:0]  S_SEND  = 3'd1;
    localparam logic [2:0]  S_TAIL  = 3'd2;
    localparam logic [2:0]  S_DRAIN = 3'd3;
    localparam logic [2:0]  S_DONE  = 3'd4;
    localparam logic [31:0] EMASK   = (32'd1 << ERR_SHIFT) - 32'd1;

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] dlfsr_q, dlfsr_d;
    logic [31:0] elfsr_q, elfsr_d;
    logic [15:0] bit_err_q, bit_err_d;
    logic [15:0] inj_q, inj_d;
    logic        pass_q, pass_d;
    logic [1:0]  ref_q [DEC_LAT];
    logic        go, send, active, trig, miss;
    logic [1:0]  mask;
    logic [16:0] inj_sum, err_sum;

    assign go     = (state_q == S_IDLE) && start_i;
    assign send   = state_q == S_SEND;
    assign active = send || (state_q == S_TAIL);
    assign trig   = active && (ERR_SHIFT > 0) && ((elfsr_q & EMASK) == EMASK);

`ifdef VITERBI_ERR_BURST_EN
    logic burst_q;
    // A trigger arms one follow-on symbol; gating by active truncates bursts at the end of TAIL
    assign mask = (trig || (active && burst_q)) ? 2'b11 : 2'b00;
    // Burst extension flag: set by any trigger, so a trigger mid-burst stretches it by one symbol
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) burst_q <= 1'b0;
        else      burst_q <= trig;
    end
`else
    assign mask = trig ? (elfsr_q[28] ? 2'b10 : 2'b01) : 2'b00;
`endif

    assign miss    = ref_q[DEC_LAT-1][1] && (ref_q[DEC_LAT-1][0] != dec_bit_i);
    assign inj_sum = {1'b0, inj_q} + {16'b0, mask[1]} + {16'b0, mask[0]};
    assign err_sum = {1'b0, bit_err_q} + {16'b0, miss};

    // Frame phase sequencing: cnt_q counts cycles within the current phase
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                state_d = start_i ? S_SEND : S_IDLE;
            end
            S_SEND: if (cnt_q == 16'(FRAME_LEN - 1)) begin
                cnt_d   = '0;
                state_d = (TAIL > 0) ? S_TAIL : S_DRAIN;
            end
            S_TAIL: if (cnt_q == 16'(TAIL - 1)) begin
                cnt_d   = '0;
                state_d = S_DRAIN;
            end
            S_DRAIN: if (cnt_q == 16'(DEC_LAT - 1)) begin
                cnt_d   = '0;
                state_d = S_DONE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // LFSR stepping, saturating counters and the pass verdict
    always_comb begin
        dlfsr_d   = go ? LFSR_SEED : send ? {dlfsr_q[0] ^ dlfsr_q[2] ^ dlfsr_q[3] ^ dlfsr_q[5], dlfsr_q[15:1]} : dlfsr_q;
        elfsr_d   = go ? 32'h1 : active ? {elfsr_q[0] ^ elfsr_q[10] ^ elfsr_q[30] ^ elfsr_q[31], elfsr_q[31:1]} : elfsr_q;
        inj_d     = go ? 16'h0 : inj_sum[16] ? 16'hFFFF : inj_sum[15:0];
        bit_err_d = go ? 16'h0 : err_sum[16] ? 16'hFFFF : err_sum[15:0];
        pass_d    = go ? 1'b0 : (state_q == S_DONE) ? (bit_err_q == 16'h0) : pass_q;
    end

    // Control and statistics registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dlfsr_q   <= LFSR_SEED;
            elfsr_q   <= 32'h1;
            inj_q     <= '0;
            bit_err_q <= '0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dlfsr_q   <= dlfsr_d;
            elfsr_q   <= elfsr_d;
            inj_q     <= inj_d;
            bit_err_q <= bit_err_d;
            pass_q    <= pass_d;
        end
    end

    // Reference line: {data_tag, sent bit} delayed to line up with the decoder output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEC_LAT; i++) ref_q[i] <= 2'b00;
        end else begin
            ref_q[0] <= {send, enc_bit_o};
            for (int i = 1; i < DEC_LAT; i++) ref_q[i] <= ref_q[i-1];
        end
    end

    assign enc_en_o     = active;
    assign enc_bit_o    = send && dlfsr_q[0];
    assign err_mask_o   = mask;
    assign busy_o       = state_q != S_IDLE;
    assign done_o       = state_q == S_DONE;
    assign pass_o       = pass_q;
    assign bit_err_ct_o = bit_err_q;
    assign inj_ct_o     = inj_q;
endmodule

// File: tb/tb_viterbi_ber_ctrl.sv
// tb_viterbi_ber_ctrl: directed table-driven bench for viterbi_ber_ctrl with an ideal delayed-decoder model.
module tb_viterbi_ber_ctrl;
    localparam int ES = 4;

    typedef struct {
        logic inv;
        logic extra;
        int   err;
        logic pass;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        inv = 1'b0;
    logic [15:0] dline = '0;
    logic        dec;
    logic        en_en, en_bit, busy, done, pass;
    logic [1:0]  mask;
    logic [15:0] err_ct, inj_ct;
    logic        z_en, z_bit, z_busy, z_done, z_pass;
    logic [1:0]  z_mask;
    logic [15:0] z_err, z_inj;

    int          total = 0;
    int          bad = 0;
    int          trace_err, dones, m_inj;
    logic [15:0] md;
    logic [31:0] me;
    logic        mb;
    logic [3:0]  first4;
    vec_t        tbl [4];

    assign dec = dline[15] ^ inv;

    viterbi_ber_ctrl u_dut (
        .clk(clk), .rst(rst), .start_i(start), .dec_bit_i(dec),
        .enc_en_o(en_en), .enc_bit_o(en_bit), .err_mask_o(mask), .busy_o(busy),
        .done_o(done), .pass_o(pass), .bit_err_ct_o(err_ct), .inj_ct_o(inj_ct)
    );

    viterbi_ber_ctrl #(.ERR_SHIFT(0)) u_z (
        .clk(clk), .rst(rst), .start_i(start), .dec_bit_i(dec),
        .enc_en_o(z_en), .enc_bit_o(z_bit), .err_mask_o(z_mask), .busy_o(z_busy),
        .done_o(z_done), .pass_o(z_pass), .bit_err_ct_o(z_err), .inj_ct_o(z_inj)
    );

    always #5 clk = ~clk;

    always @(posedge clk) dline <= {dline[14:0], en_bit};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic run_frame(input logic iv, input logic ex);
        logic       snd, act, trig, eb;
        logic [1:0] emk;
        inv = iv;
        md = 16'hACE1;
        me = 32'h1;
        mb = 1'b0;
        m_inj = 0;
        trace_err = 0;
        dones = 0;
        first4 = '0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 280; k++) begin
            @(negedge clk);
            start = ex && (k == 50 || k == 200);
            snd  = k <= 256;
            act  = k <= 258;
            trig = act && ((me & ((32'd1 << ES) - 32'd1)) == ((32'd1 << ES) - 32'd1));
`ifdef VITERBI_ERR_BURST_EN
            emk = (trig || (act && mb)) ? 2'b11 : 2'b00;
            mb  = trig;
`else
            emk = trig ? (me[28] ? 2'b10 : 2'b01) : 2'b00;
`endif
            eb = snd && md[0];
            if (k <= 4) first4[k-1] = en_bit;
            if ({en_en, en_bit, mask, busy, done} !== {act, eb, emk, k <= 275, k == 275}) trace_err++;
            if ({z_en, z_bit, z_mask, z_busy, z_done} !== {act, eb, 2'b00, k <= 275, k == 275}) trace_err++;
            if (done) dones++;
            m_inj += int'(emk[1]) + int'(emk[0]);
            if (act) me = {me[0] ^ me[10] ^ me[30] ^ me[31], me[31:1]};
            if (snd) md = {md[0] ^ md[2] ^ md[3] ^ md[5], md[15:1]};
        end
        start = 1'b0;
    endtask

    initial begin
        tbl[0] = '{inv: 1'b0, extra: 1'b0, err: 0,   pass: 1'b1};
        tbl[1] = '{inv: 1'b1, extra: 1'b0, err: 256, pass: 1'b0};
        tbl[2] = '{inv: 1'b0, extra: 1'b1, err: 0,   pass: 1'b1};
        tbl[3] = '{inv: 1'b1, extra: 1'b1, err: 256, pass: 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_ctl", {26'b0, en_en, en_bit, mask, busy, done, pass}, 0);
        chk("reset_cnt", {err_ct, inj_ct}, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ctl", {26'b0, en_en, en_bit, mask, busy, done, pass}, 0);

        for (int r = 0; r < 4; r++) begin
            run_frame(tbl[r].inv, tbl[r].extra);
            chk($sformatf("r%0d_trace_mism", r), trace_err, 0);
            chk($sformatf("r%0d_done_count", r), dones, 1);
            chk($sformatf("r%0d_first4", r), {28'b0, first4}, 4'b0001);
            chk($sformatf("r%0d_bit_err", r), {16'b0, err_ct}, tbl[r].err);
            chk($sformatf("r%0d_pass", r), {31'b0, pass}, {31'b0, tbl[r].pass});
            chk($sformatf("r%0d_inj", r), {16'b0, inj_ct}, m_inj);
            chk($sformatf("r%0d_z_inj", r), {16'b0, z_inj}, 0);
            chk($sformatf("r%0d_z_bit_err", r), {16'b0, z_err}, tbl[r].err);
            chk($sformatf("r%0d_z_pass", r), {31'b0, z_pass}, {31'b0, tbl[r].pass});
        end
        repeat (5) @(negedge clk);
        chk("hold_bit_err", {16'b0, err_ct}, 256);
        chk("hold_pass", {31'b0, pass}, 0);

        inv = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (100) @(negedge clk);
        chk("abort_pre_err", {16'b0, err_ct}, 83);
        rst = 1'b0;
        #1;
        chk("abort_ctl", {26'b0, en_en, en_bit, mask, busy, done, pass}, 0);
        chk("abort_cnt", {err_ct, inj_ct}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        dones = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        chk("abort_no_done", dones, 0);
        run_frame(1'b0, 1'b0);
        chk("restart_trace", trace_err, 0);
        chk("restart_first4", {28'b0, first4}, 4'b0001);
        chk("restart_pass", {31'b0, pass}, 1);

        inv = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 277; k++) begin
            @(negedge clk);
            if (k == 275) chk("cont_done", {31'b0, done}, 1);
            if (k == 276) chk("cont_idle_gap", {30'b0, busy, done}, 0);
            if (k == 277) chk("cont_restart", {30'b0, en_en, en_bit}, 2'b11);
        end
        start = 1'b0;
        for (int k = 0; k < 400 && busy; k++) @(negedge clk);
        chk("cont_end_idle", {31'b0, busy}, 0);
        chk("cont_pass", {31'b0, pass}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
